// File: rtl/rr_arbiter_4to1.sv
// Four-requester arbiter with a one-word registered output stage.
// Define RR_ARBITER_FIXED_PRIO_EN for fixed priority (0 highest); default is round-robin.
module rr_arbiter_4to1 #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [3:0]       ack,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [1:0]       sel
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        y_q, y_d;
  logic [1:0]              sel_q, sel_d;
  logic [1:0]              ptr_q, ptr_d;
  logic [3:0][WIDTH-1:0]   din;
  logic [1:0]              base, win, idx;
  logic                    found, cap;

  assign din = {i3, i2, i1, i0};

`ifdef RR_ARBITER_FIXED_PRIO_EN
  assign base = 2'd0;
`else
  assign base = ptr_q;
`endif

  // Search upward from base; the 2-bit index wraps 3 -> 0 on its own.
  always_comb begin
    found = 1'b0;
    win   = base;
    idx   = base;
    for (int k = 0; k < 4; k++) begin
      idx = base + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cap     = !rst && found && (state_q == EMPTY || y_ready);
    ack     = cap ? (4'b0001 << win) : 4'b0000;
    if (cap) begin
      state_d = FULL;
      y_d     = din[win];
      sel_d   = win;
      ptr_d   = win + 2'd1;
    end else if (state_q == FULL && y_ready) begin
      // Drained with nothing waiting: keep y/sel, just mark empty.
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      y_q     <= '0;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign y       = y_q;
  assign sel     = sel_q;
  assign y_valid = (state_q == FULL);

endmodule

// File: tb/tb_rr_arbiter_4to1.sv
// Bench for rr_arbiter_4to1: per-cycle reference model plus directed literal checks.
module tb_rr_arbiter_4to1;

`ifdef RR_ARBITER_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req = 4'b0;
  logic [2:0] i0 = 3'd0, i1 = 3'd0, i2 = 3'd0, i3 = 3'd0;
  logic [3:0] ack;
  logic [2:0] y;
  logic       y_valid;
  logic       y_ready = 1'b1;
  logic [1:0] sel;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: the held word and the round-robin pointer.
  bit       m_valid = 0;
  int       m_y     = 0;
  int       m_sel   = 0;
  int       m_ptr   = 0;

  rr_arbiter_4to1 #(.WIDTH(3)) dut (
    .clk(clk), .rst(rst), .req(req), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .ack(ack), .y(y), .y_valid(y_valid), .y_ready(y_ready), .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int data_of(input int r);
    case (r)
      0: return int'(i0);
      1: return int'(i1);
      2: return int'(i2);
      default: return int'(i3);
    endcase
  endfunction

  // Winner index or -1 when nothing is captured this cycle.
  function automatic int model_winner();
    int start;
    if (rst === 1'b1 || req == 4'b0) return -1;
    if (m_valid && !y_ready) return -1;
    start = FIXED ? 0 : m_ptr;
    for (int k = 0; k < 4; k++)
      if (req[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  function automatic int model_ack();
    int w;
    w = model_winner();
    return (w < 0) ? 0 : (1 << w);
  endfunction

  always @(posedge clk or posedge rst) begin
    int w;
    if (rst) begin
      m_valid = 0; m_y = 0; m_sel = 0; m_ptr = 0;
    end else begin
      w = model_winner();
      if (w >= 0) begin
        m_y = data_of(w); m_sel = w; m_valid = 1; m_ptr = (w + 1) % 4;
      end else if (m_valid && y_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_ack",     int'(ack),     model_ack());
    chk("model_y_valid", int'(y_valid), int'(m_valid));
    chk("model_y",       int'(y),       m_y);
    chk("model_sel",     int'(sel),     m_sel);
  end

  initial begin
    int exp_y[5];
    exp_y = '{2, 3, 5, 6, 2};
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_y_valid", int'(y_valid), 0);
    chk("reset_y",       int'(y),       0);
    chk("reset_sel",     int'(sel),     0);
    chk("reset_ack",     int'(ack),     0);

    // Single request from EMPTY: ack same cycle, data one clock later.
    @(posedge clk); #1; rst = 1'b0; i0 = 3'b010; req = 4'b0001; y_ready = 1'b1;
    @(negedge clk); chk("first_ack", int'(ack), 4'b0001);
    @(posedge clk); #1; req = 4'b0000;
    @(negedge clk);
    chk("first_y", int'(y), 3'b010);
    chk("first_sel", int'(sel), 0);
    chk("first_valid", int'(y_valid), 1);
    @(negedge clk);
    chk("drain_valid", int'(y_valid), 0);
    chk("drain_y_kept", int'(y), 3'b010);

    // All requesting, downstream always ready: one word per clock.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    i0 = 3'b010; i1 = 3'b011; i2 = 3'b101; i3 = 3'b110; req = 4'b1111;
    @(negedge clk); chk("all_ack0", int'(ack), 4'b0001);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("all_sel",   int'(sel),     FIXED ? 0 : k % 4);
      chk("all_y",     int'(y),       FIXED ? 2 : exp_y[k]);
      chk("all_valid", int'(y_valid), 1);
    end
    @(posedge clk); #1; req = 4'b0000;

    // Backpressure holds the word; release then grants the waiting requester.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; req = 4'b0001; y_ready = 1'b0;
    @(negedge clk); chk("bp_cap_ack", int'(ack), 4'b0001);
    @(posedge clk); #1; req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_y",   int'(y),       3'b010);
      chk("bp_sel", int'(sel),     0);
      chk("bp_ack", int'(ack),     0);
      chk("bp_vld", int'(y_valid), 1);
      if (k < 2) @(posedge clk);
    end
    @(posedge clk); #1; y_ready = 1'b1;
    @(negedge clk); chk("bp_release_ack", int'(ack), 4'b0100);

    // Wrap-around: pointer sits at 3 after the grant to 2.
    @(posedge clk); #1; req = 4'b1001;
    @(negedge clk);
    chk("wrap_y2",   int'(y),   3'b101);
    chk("wrap_sel2", int'(sel), 2);
    chk("wrap_ack1", int'(ack), FIXED ? 4'b0001 : 4'b1000);
    @(posedge clk); #1; req = FIXED ? 4'b1000 : 4'b0001;
    @(negedge clk);
    chk("wrap_sel_a", int'(sel), FIXED ? 0 : 3);
    chk("wrap_ack2",  int'(ack), FIXED ? 4'b1000 : 4'b0001);
    @(posedge clk); #1; req = 4'b0000;
    @(negedge clk); chk("wrap_sel_b", int'(sel), FIXED ? 3 : 0);

    // Asynchronous reset while FULL discards the word immediately.
    @(posedge clk); #1; req = 4'b0010; y_ready = 1'b1;
    @(posedge clk); #1; req = 4'b0000; y_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", int'(y_valid), 1);
    chk("pre_rst_sel",   int'(sel),     1);
    chk("pre_rst_y",     int'(y),       3'b011);
    #2; rst = 1'b1;
    #1;
    chk("async_rst_valid", int'(y_valid), 0);
    chk("async_rst_y",     int'(y),       0);
    chk("async_rst_sel",   int'(sel),     0);
    chk("async_rst_ack",   int'(ack),     0);
    @(posedge clk); #1; rst = 1'b0; req = 4'b1010; y_ready = 1'b1;
    @(negedge clk); chk("post_rst_ack", int'(ack), 4'b0010);
    @(posedge clk); #1; req = 4'b1000;
    @(negedge clk);
    chk("post_rst_sel", int'(sel), 1);
    chk("post_rst_y",   int'(y),   3'b011);
    chk("post_rst_ack2", int'(ack), 4'b1000);
    @(posedge clk); #1; req = 4'b0000;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
